// File: rtl/double_pkg.sv
// Shared widths, constants, FSM states and the unpacked-operand layout for the
// binary64 multiplier.
package double_pkg;

    localparam int unsigned W      = 64;
    localparam int unsigned EXP_W  = 13;
    localparam int unsigned MANT_W = 53;
    localparam int unsigned PROD_W = 106;

    localparam logic signed [EXP_W-1:0] EXP_BIAS = 13'sd1023;
    localparam logic signed [EXP_W-1:0] EXP_MIN  = -13'sd1022;
    localparam logic signed [EXP_W-1:0] EXP_MAX  = 13'sd1023;

    localparam logic [W-1:0] QNAN = 64'h7FF8000000000000;
    localparam logic [W-1:0] INF  = 64'h7FF0000000000000;

    typedef enum logic [3:0] {
        ST_GET,
        ST_UNPACK,
        ST_SPECIAL,
        ST_NORM_A,
        ST_NORM_B,
        ST_MUL0,
        ST_MUL1,
        ST_NORM1,
        ST_NORM2,
        ST_ROUND,
        ST_PACK,
        ST_PUT
    } state_e;

    typedef struct packed {
        logic                    sign;
        logic signed [EXP_W-1:0] exp;
        logic [MANT_W-1:0]       mant;
    } operand_t;

endpackage

// File: rtl/double_unpack.sv
// Splits a binary64 word into sign / unbiased exponent / mantissa-with-hidden-bit
// and flags the special classes (NaN, infinity, zero).
module double_unpack
    import double_pkg::*;
(
    input  logic [W-1:0] x,
    output operand_t     op_c,
    output logic         is_nan_c,
    output logic         is_inf_c,
    output logic         is_zero_c
);

    logic [10:0] exp_raw;
    logic [51:0] frac;

    assign exp_raw = x[62:52];
    assign frac    = x[51:0];

    // Subnormals share the minimum exponent but have no hidden bit.
    always_comb begin
        op_c.sign = x[63];
        op_c.exp  = (exp_raw == 11'd0) ? EXP_MIN
                                       : $signed({2'b00, exp_raw}) - EXP_BIAS;
        op_c.mant = {(exp_raw != 11'd0), frac};
    end

    assign is_nan_c  = (exp_raw == 11'h7FF) && (frac != 52'd0);
    assign is_inf_c  = (exp_raw == 11'h7FF) && (frac == 52'd0);
    assign is_zero_c = (exp_raw == 11'd0)   && (frac == 52'd0);

endmodule

// File: rtl/double_mul.sv
// IEEE-754 binary64 multiplier, round-to-nearest-even with subnormal support.
// Sequential datapath with stb/ack handshakes on operand and result sides.
module double_mul
    import double_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_stb,
    output logic         in_ack,
    output logic [W-1:0] z,
    output logic         z_stb,
    input  logic         z_ack
);

    state_e                  state_q, state_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    operand_t                opa_q, opa_d, opb_q, opb_d;
    logic                    z_sign_q, z_sign_d;
    logic signed [EXP_W-1:0] z_exp_q, z_exp_d;
    logic [MANT_W-1:0]       z_mant_q, z_mant_d;
    logic [PROD_W-1:0]       prod_q, prod_d;
    logic                    guard_q, guard_d;
    logic                    round_q, round_d;
    logic                    sticky_q, sticky_d;
    logic [W-1:0]            z_q, z_d;
    logic                    z_stb_q, z_stb_d;
    logic                    in_ack_q, in_ack_d;

    operand_t                ua_op_c, ub_op_c;
    logic                    a_nan_c, a_inf_c, a_zero_c;
    logic                    b_nan_c, b_inf_c, b_zero_c;
    logic [MANT_W:0]         mant_inc_c;
    logic [10:0]             biased_c;
    logic                    sign_c;

    double_unpack u_unpack_a (
        .x         (a_q),
        .op_c      (ua_op_c),
        .is_nan_c  (a_nan_c),
        .is_inf_c  (a_inf_c),
        .is_zero_c (a_zero_c)
    );

    double_unpack u_unpack_b (
        .x         (b_q),
        .op_c      (ub_op_c),
        .is_nan_c  (b_nan_c),
        .is_inf_c  (b_inf_c),
        .is_zero_c (b_zero_c)
    );

    assign mant_inc_c = {1'b0, z_mant_q} + (MANT_W+1)'(1);
    assign biased_c   = 11'(z_exp_q + EXP_BIAS);
    assign sign_c     = a_q[63] ^ b_q[63];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_GET;
            a_q      <= '0;
            b_q      <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            z_sign_q <= 1'b0;
            z_exp_q  <= '0;
            z_mant_q <= '0;
            prod_q   <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            z_q      <= '0;
            z_stb_q  <= 1'b0;
            in_ack_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            z_sign_q <= z_sign_d;
            z_exp_q  <= z_exp_d;
            z_mant_q <= z_mant_d;
            prod_q   <= prod_d;
            guard_q  <= guard_d;
            round_q  <= round_d;
            sticky_q <= sticky_d;
            z_q      <= z_d;
            z_stb_q  <= z_stb_d;
            in_ack_q <= in_ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        z_sign_d = z_sign_q;
        z_exp_d  = z_exp_q;
        z_mant_d = z_mant_q;
        prod_d   = prod_q;
        guard_d  = guard_q;
        round_d  = round_q;
        sticky_d = sticky_q;
        z_d      = z_q;
        z_stb_d  = z_stb_q;
        in_ack_d = in_ack_q;

        unique case (state_q)
            ST_GET: begin
                if (in_stb && in_ack_q) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    in_ack_d = 1'b0;
                    state_d  = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                opa_d   = ua_op_c;
                opb_d   = ub_op_c;
                state_d = ST_SPECIAL;
            end
            ST_SPECIAL: begin
                z_sign_d = sign_c;
                if (a_nan_c || b_nan_c || (a_inf_c && b_zero_c) || (a_zero_c && b_inf_c)) begin
                    z_d     = QNAN;
                    z_stb_d = 1'b1;
                    state_d = ST_PUT;
                end else if (a_inf_c || b_inf_c) begin
                    z_d     = INF | {sign_c, 63'd0};
                    z_stb_d = 1'b1;
                    state_d = ST_PUT;
                end else if (a_zero_c || b_zero_c) begin
                    z_d     = {sign_c, 63'd0};
                    z_stb_d = 1'b1;
                    state_d = ST_PUT;
                end else begin
                    state_d = ST_NORM_A;
                end
            end
            ST_NORM_A: begin
                if (!opa_q.mant[MANT_W-1]) begin
                    opa_d.mant = opa_q.mant << 1;
                    opa_d.exp  = opa_q.exp - 13'sd1;
                end else begin
                    state_d = ST_NORM_B;
                end
            end
            ST_NORM_B: begin
                if (!opb_q.mant[MANT_W-1]) begin
                    opb_d.mant = opb_q.mant << 1;
                    opb_d.exp  = opb_q.exp - 13'sd1;
                end else begin
                    state_d = ST_MUL0;
                end
            end
            ST_MUL0: begin
                prod_d  = PROD_W'(opa_q.mant) * PROD_W'(opb_q.mant);
                z_exp_d = opa_q.exp + opb_q.exp + 13'sd1;
                state_d = ST_MUL1;
            end
            ST_MUL1: begin
                z_mant_d = prod_q[105:53];
                guard_d  = prod_q[52];
                round_d  = prod_q[51];
                sticky_d = |prod_q[50:0];
                state_d  = ST_NORM1;
            end
            ST_NORM1: begin
                if (!z_mant_q[MANT_W-1] && (z_exp_q > EXP_MIN)) begin
                    z_mant_d = {z_mant_q[51:0], guard_q};
                    guard_d  = round_q;
                    round_d  = 1'b0;
                    z_exp_d  = z_exp_q - 13'sd1;
                end else begin
                    state_d = ST_NORM2;
                end
            end
            // Denormalise towards the minimum exponent, collecting shifted-out bits.
            ST_NORM2: begin
                if (z_exp_q < EXP_MIN) begin
                    z_mant_d = z_mant_q >> 1;
                    guard_d  = z_mant_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                    z_exp_d  = z_exp_q + 13'sd1;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (guard_q && (round_q || sticky_q || z_mant_q[0])) begin
                    if (mant_inc_c[MANT_W]) begin
                        z_mant_d = mant_inc_c[MANT_W:1];
                        z_exp_d  = z_exp_q + 13'sd1;
                    end else begin
                        z_mant_d = mant_inc_c[MANT_W-1:0];
                    end
                end
                state_d = ST_PACK;
            end
            ST_PACK: begin
                if (z_exp_q > EXP_MAX) begin
                    z_d = INF | {z_sign_q, 63'd0};
                end else if ((z_exp_q == EXP_MIN) && !z_mant_q[MANT_W-1]) begin
                    z_d = {z_sign_q, 11'd0, z_mant_q[51:0]};
                end else begin
                    z_d = {z_sign_q, biased_c, z_mant_q[51:0]};
                end
                z_stb_d = 1'b1;
                state_d = ST_PUT;
            end
            ST_PUT: begin
                if (z_ack) begin
                    z_stb_d  = 1'b0;
                    in_ack_d = 1'b1;
                    state_d  = ST_GET;
                end
            end
            default: begin
                state_d = ST_GET;
            end
        endcase
    end

    assign in_ack = in_ack_q;
    assign z      = z_q;
    assign z_stb  = z_stb_q;

endmodule
